// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential population counter family.
// Holds the FSM state encoding, the count-mode constants and the result-width helper.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    // Bits needed to hold a count in the range 0..width inclusive.
    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/popcount_comb.sv
// Purely combinational W-bit population count; drop-in generalisation of count32.
// Output width is just wide enough to hold W.
module popcount_comb
    import popcount_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]           data,
    output logic [$clog2(W+1)-1:0] count
);

    localparam int CW = cw_of(W);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Sequential population counter: counts LANES bits per clock of a WIDTH-bit word,
// ones or zeros selected per word, with valid/ready handshakes on both sides.
module popcount_seq
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] out_count,
    output logic                       busy
);

    localparam int N     = WIDTH / LANES;
    localparam int CW    = cw_of(WIDTH);
    localparam int SW    = cw_of(LANES);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_bad_params
        $fatal(1, "popcount_seq: illegal LANES=%0d for WIDTH=%0d", LANES, WIDTH);
    end

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shift_q;
    logic [CW-1:0]      acc_q;
    logic [CNT_W-1:0]   chunk_q;
    logic [SW-1:0]      lane_cnt;
    logic               last_chunk;

    popcount_comb #(
        .W(LANES)
    ) u_lane_count (
        .data  (shift_q[LANES-1:0]),
        .count (lane_cnt)
    );

    assign last_chunk = (chunk_q == CNT_W'(N - 1));
    assign out_count  = acc_q;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Zeros mode inverts the word once at load so the datapath only ever counts ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= (in_mode == MODE_ZEROS) ? ~in_data : in_data;
                        acc_q   <= '0;
                        chunk_q <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_q + CW'(lane_cnt);
                    shift_q <= shift_q >> LANES;
                    chunk_q <= chunk_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: directed and random words against a behavioural model,
// plus a parameter sweep over several WIDTH/LANES instances.
module tb_popcount_seq;

    localparam int MN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_count;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    popcount_seq #(.WIDTH(32), .LANES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int ref_pop(input logic [63:0] d, input int w, input logic mode);
        int c = 0;
        for (int i = 0; i < w; i++) c += (mode ? !d[i] : d[i]) ? 1 : 0;
        return c;
    endfunction

    // Behavioural model: a word is pending from acceptance until its result is taken;
    // the result becomes visible MN edges after acceptance.
    int  cyc    = 0;
    bit  m_pend = 0;
    int  m_exp  = 0;
    int  m_rdy  = 0;
    bit  chk_en = 0;

    always @(posedge clk) begin
        bit ev;
        ev = m_pend && (cyc >= m_rdy);
        cyc++;
        if (rst) m_pend = 0;
        else if (m_pend) begin
            if (ev && out_ready) m_pend = 0;
        end else if (in_valid) begin
            m_pend = 1;
            m_exp  = ref_pop({32'h0, in_data}, 32, in_mode);
            m_rdy  = cyc + MN;
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = m_pend && (cyc >= m_rdy);
            check("out_valid", out_valid, ev);
            check("in_ready", in_ready, !m_pend);
            check("busy", busy, m_pend);
            if (ev) check("out_count", out_count, m_exp);
        end
    end

    task automatic wait_ready(input string name);
        int b = 0;
        while (!in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name);
        int b = 0;
        while (!out_valid && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) check({name, "_valid_timeout"}, 0, 1);
    endtask

    // Sends one word with out_ready high; checks latency and the literal count.
    task automatic run_word(input string name, input logic [31:0] d, input logic m,
                            input int exp, output int t_acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        wait_ready(name);
        @(posedge clk);
        #1 t_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(name);
        check({name, "_lat"}, cyc - t_acc, 4);
        check({name, "_count"}, out_count, exp);
        @(posedge clk);
    endtask

    // Parameter sweep instances
    localparam int SW_W   [4] = '{32, 32, 32, 64};
    localparam int SW_L   [4] = '{1, 4, 32, 16};
    localparam int SW_LAT [4] = '{32, 8, 1, 4};

    logic       rst_sw;
    bit         sweep_go = 0;
    logic [3:0] sw_done  = '0;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = SW_W[g];
        logic                    s_in_valid, s_in_ready, s_in_mode;
        logic                    s_out_valid, s_out_ready, s_busy;
        logic [W-1:0]            s_in_data;
        logic [$clog2(W+1)-1:0]  s_out_count;

        popcount_seq #(.WIDTH(W), .LANES(SW_L[g])) u_dut (
            .clk       (clk),
            .rst       (rst_sw),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .in_data   (s_in_data),
            .in_mode   (s_in_mode),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .out_count (s_out_count),
            .busy      (s_busy)
        );

        initial begin
            logic [63:0] d;
            logic        md;
            int          lat;
            int          b;
            s_in_valid  = 1'b0;
            s_out_ready = 1'b0;
            s_in_data   = '0;
            s_in_mode   = 1'b0;
            wait (sweep_go);
            for (int i = 0; i < 12; i++) begin
                d  = {$urandom(), $urandom()};
                md = 1'($urandom_range(0, 1));
                if (i == 0) begin d = '1; md = 1'b0; end
                if (i == 1) begin d = '0; md = 1'b0; end
                @(negedge clk);
                s_in_valid = 1'b1;
                s_in_data  = d[W-1:0];
                s_in_mode  = md;
                b = 0;
                while (!s_in_ready && b < 200) begin @(negedge clk); b++; end
                if (b >= 200) check($sformatf("sw%0d_ready_timeout", g), 0, 1);
                @(posedge clk);
                @(negedge clk);
                s_in_valid = 1'b0;
                lat = 0;
                while (!s_out_valid && lat < 100) begin @(negedge clk); lat++; end
                check($sformatf("sw%0d_lat", g), lat, SW_LAT[g]);
                check($sformatf("sw%0d_count", g), s_out_count, ref_pop(d, W, md));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("sw%0d_hold", g), s_out_count, ref_pop(d, W, md));
                s_out_ready = 1'b1;
                @(negedge clk);
                check($sformatf("sw%0d_taken", g), s_out_valid, 0);
                s_out_ready = 1'b0;
            end
            sw_done[g] = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tprev, b;
        rst       = 1'b1;
        rst_sw    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_out_count", out_count, 0);

        // Scenario 1 and 2: ones mode, back-to-back words
        run_word("zero", 32'h0, 1'b0, 0, t);
        run_word("s2_a", 32'h1, 1'b0, 1, tprev);
        run_word("s2_b", 32'hffff_ffff, 1'b0, 32, t);
        check("thru_b", t - tprev, 6);
        tprev = t;
        run_word("s2_c", 32'hffff_0000, 1'b0, 16, t);
        check("thru_c", t - tprev, 6);
        tprev = t;
        run_word("s2_d", 32'h0, 1'b0, 0, t);
        check("thru_d", t - tprev, 6);

        // Scenario 3: zeros mode
        run_word("z_a", 32'h0, 1'b1, 32, t);
        run_word("z_b", 32'hffff_0000, 1'b1, 16, t);
        run_word("z_c", 32'h8000_0001, 1'b1, 30, t);

        // Scenario 4: backpressure with a pending input word
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hf0f0_f0f0;
        in_mode   = 1'b0;
        wait_ready("bp");
        @(posedge clk);
        @(negedge clk);
        in_data = 32'h0000_0007;
        wait_valid("bp");
        check("bp_count", out_count, 16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", out_count, 16);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_taken", busy, 1);
        wait_valid("bp2");
        check("bp_pending_count", out_count, 3);
        @(posedge clk);

        // Scenario 5: reset during RUN at chunk 2
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hdead_beef;
        in_mode  = 1'b0;
        wait_ready("mr");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_in_ready", in_ready, 1);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_count", out_count, 0);
        run_word("mr_after", 32'h0000_00ff, 1'b0, 8, t);

        // Random traffic with random backpressure, checked by the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom();
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        b = 0;
        while (busy && b < 50) begin @(negedge clk); b++; end
        if (b >= 50) check("drain_timeout", 0, 1);

        // Parameter sweep
        @(negedge clk);
        rst_sw   = 1'b0;
        sweep_go = 1;
        b = 0;
        while (sw_done != 4'hf && b < 20000) begin @(negedge clk); b++; end
        if (b >= 20000) check("sweep_timeout", 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
